// File: rtl/jt49_bus_mc_if.sv
// CPU-side PSG pins plus the fan-out bus towards NCH jt49 cores.
interface jt49_bus_mc_if #(
    parameter int NCH = 2
);
    logic             bdir;
    logic             bc2;
    logic             bc1;
    logic [7:0]       din;
    logic [7:0]       dout;
    logic [8*NCH-1:0] core_rdata;
    logic [3:0]       core_addr;
    logic [7:0]       core_din;
    logic [NCH-1:0]   core_cs_n;
    logic             core_wr_n;
    logic [1:0]       chip_sel;
    logic             busy;
    logic             ovf;

    modport master (
        output bdir, bc2, bc1, din, core_rdata,
        input  dout, core_addr, core_din, core_cs_n, core_wr_n, chip_sel, busy, ovf
    );

    modport slave (
        input  bdir, bc2, bc1, din, core_rdata,
        output dout, core_addr, core_din, core_cs_n, core_wr_n, chip_sel, busy, ovf
    );
endinterface

// File: rtl/jt49_bus_mc.sv
// Multi-chip PSG bus front end: BDIR/BC2/BC1 decode, chip select and a write FIFO feeding NCH jt49 cores.
// Core write strobe lands 3 clk after the WRITE pins are sampled; the CPU never stalls, writes into a full FIFO are dropped and flagged.
module jt49_bus_mc #(
    parameter int         NCH     = 2,
    parameter logic [3:0] ADDR_HI = 4'h0,
    parameter int         FDEPTH  = 4
) (
    input logic          clk,
    input logic          rst,
    jt49_bus_mc_if.slave bus
);
    localparam int AW = $clog2(FDEPTH);
    localparam logic [2:0] P_READ  = 3'b011;
    localparam logic [2:0] P_WRITE = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_GAP} state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] addr;
        logic [7:0] dat;
    } wr_ent_t;

    logic [2:0]     s1, s2;
    logic [7:0]     d1;
    logic [3:0]     addr_lat;
    logic           addr_ok;
    logic [1:0]     chip_sel;
    logic [1:0]     cand;
    logic           act, is_latch;
    wr_ent_t        fifo_mem [FDEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           full, empty, push_req, push, pop;
    state_t         state, state_nx;
    wr_ent_t        ent;
    logic           busy, rd_cond, rd_q, ovf;
    logic [7:0]     rsel;
    logic [7:0]     dout;
    logic [3:0]     core_addr;
    logic [7:0]     core_din;
    logic [NCH-1:0] core_cs_n;
    logic           core_wr_n;

    function automatic logic [NCH-1:0] sel_mask(input logic [1:0] sel);
        logic [NCH-1:0] m;
        m = '1;
        for (int k = 0; k < NCH; k++)
            if (sel == 2'(k)) m[k] = 1'b0;
        return m;
    endfunction

    // Two-stage pin sampling; an action fires only on the cycle the decoded pins change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 3'b000;
            s2 <= 3'b000;
            d1 <= 8'h00;
        end else begin
            s1 <= {bus.bdir, bus.bc2, bus.bc1};
            s2 <= s1;
            d1 <= bus.din;
        end
    end

    assign act      = (s1 != s2);
    assign is_latch = (s1 == 3'b001) || (s1 == 3'b100) || (s1 == 3'b111);
    assign cand     = ~d1[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lat <= 4'h0;
            addr_ok  <= 1'b1;
            chip_sel <= 2'd0;
        end else if (act && is_latch) begin
            if (d1[7:4] == ADDR_HI) begin
                addr_lat <= d1[3:0];
                addr_ok  <= 1'b1;
            end else if (d1[7:2] == 6'h3F && NCH > 1) begin
                if (int'(cand) < NCH) begin
                    chip_sel <= cand;
                    addr_ok  <= 1'b0;
                end
            end else begin
                addr_ok <= 1'b0;
            end
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = act && (s1 == P_WRITE) && addr_ok;
    assign push     = push_req && !full;
    assign pop      = (state == ST_IDLE) && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)            wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)             rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push_req && full) ovf   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {chip_sel, addr_lat, d1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ent   <= '0;
        end else begin
            state <= state_nx;
            if (pop) ent <= fifo_mem[rd_ptr[AW-1:0]];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (!empty) state_nx = ST_STROBE;
            ST_STROBE: state_nx = ST_GAP;
            ST_GAP:    state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    assign busy    = !empty || (state != ST_IDLE);
    assign rd_cond = (s1 == P_READ) && addr_ok && !busy;

    always_comb begin
        rsel = 8'hFF;
        for (int k = 0; k < NCH; k++)
            if (chip_sel == 2'(k)) rsel = core_rdata_slice(k);
    end

    function automatic logic [7:0] core_rdata_slice(input int k);
        return bus.core_rdata[8*k +: 8];
    endfunction

    // Core-side pins are registered from the FSM state, so they trail the state by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_addr <= 4'h0;
            core_din  <= 8'h00;
            core_cs_n <= '1;
            core_wr_n <= 1'b1;
            rd_q      <= 1'b0;
            dout      <= 8'hFF;
        end else begin
            rd_q <= 1'b0;
            case (state)
                ST_STROBE: begin
                    core_cs_n <= sel_mask(ent.sel);
                    core_wr_n <= 1'b0;
                    core_addr <= ent.addr;
                    core_din  <= ent.dat;
                end
                ST_GAP: begin
                    core_cs_n <= '1;
                    core_wr_n <= 1'b1;
                end
                default: begin
                    core_cs_n <= rd_cond ? sel_mask(chip_sel) : '1;
                    core_wr_n <= 1'b1;
                    rd_q      <= rd_cond;
                    if (empty) core_addr <= addr_lat;
                end
            endcase
            // Read data is taken only once the core has seen its select for a full clock.
            if (s1 != P_READ) dout <= 8'hFF;
            else if (rd_q)    dout <= rsel;
        end
    end

    assign bus.dout      = dout;
    assign bus.core_addr = core_addr;
    assign bus.core_din  = core_din;
    assign bus.core_cs_n = core_cs_n;
    assign bus.core_wr_n = core_wr_n;
    assign bus.chip_sel  = chip_sel;
    assign bus.busy      = busy;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_jt49_bus_mc.sv
// Directed and randomized bench for jt49_bus_mc with a transaction-level model of latch/chip-select/FIFO behaviour.
module tb_jt49_bus_mc;
    localparam int NCH    = 2;
    localparam int FDEPTH = 4;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b011;
    localparam logic [2:0] OP_WRITE = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt49_bus_mc_if #(.NCH(NCH)) bus ();

    jt49_bus_mc #(.NCH(NCH), .ADDR_HI(4'h0), .FDEPTH(FDEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [3:0]  m_addr;
    logic        m_ok;
    logic [1:0]  m_chip;

    always @(negedge clk)
        if (!rst && bus.core_wr_n === 1'b0)
            obs_q.push_back({2'b00, bus.core_cs_n, bus.core_addr, bus.core_din});

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] chip, input logic [3:0] a, input logic [7:0] d);
        logic [1:0] one;
        one = 2'b01;
        return {2'b00, ~(one << chip), a, d};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] p, input logic [7:0] d);
        {bus.bdir, bus.bc2, bus.bc1} = p;
        bus.din = d;
    endtask

    task automatic bus_op(input logic [2:0] p, input logic [7:0] d);
        @(negedge clk);
        drive(p, d);
        @(negedge clk);
        drive(OP_NONE, 8'h00);
    endtask

    task automatic latch_op(input logic [7:0] d);
        logic [2:0] code;
        logic [1:0] c;
        case ($urandom_range(0, 2))
            0:       code = 3'b001;
            1:       code = 3'b100;
            default: code = 3'b111;
        endcase
        bus_op(code, d);
        c = ~d[1:0];
        if (d[7:4] == 4'h0) begin
            m_addr = d[3:0];
            m_ok   = 1'b1;
        end else if (d[7:2] == 6'h3F) begin
            if (int'(c) < NCH) begin
                m_chip = c;
                m_ok   = 1'b0;
            end
        end else begin
            m_ok = 1'b0;
        end
    endtask

    task automatic write_op(input logic [7:0] d);
        bus_op(OP_WRITE, d);
        if (m_ok) exp_q.push_back(mk(m_chip, m_addr, d));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && bus.busy !== 1'b0; k++) @(negedge clk);
        check("idle_wait", bus.busy, 1'b0);
    endtask

    task automatic drain_compare(input string tag);
        for (int k = 0; k < 400; k++) begin
            if (bus.busy === 1'b0 && obs_q.size() >= exp_q.size()) break;
            @(negedge clk);
        end
        idle(2);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_strobe"}, (i < obs_q.size()) ? {16'h0, obs_q[i]} : 32'hFFFF_FFFF, {16'h0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic read_op();
        logic [15:0] rd;
        logic [7:0]  e;
        rd = 16'($urandom);
        bus.core_rdata = rd;
        wait_idle();
        e = m_ok ? ((m_chip == 2'd0) ? rd[7:0] : rd[15:8]) : 8'hFF;
        drive(OP_READ, 8'h00);
        repeat (3) @(negedge clk);
        check("rd_dout", bus.dout, e);
        drive(OP_NONE, 8'h00);
        repeat (2) @(negedge clk);
        check("rd_end", bus.dout, 8'hFF);
    endtask

    // Occupancy model: writes arrive every 2 clk, the drain engine takes one entry per 3 clk.
    function automatic logic [31:0] ovf_model(input int n, input int depth);
        int          occ;
        int          free_at;
        bit          pop_now;
        logic [31:0] acc;
        occ     = 0;
        free_at = 0;
        acc     = '0;
        for (int t = 1; t <= 2 * n; t++) begin
            pop_now = (t >= free_at) && (occ > 0);
            if (t % 2 == 1) begin
                if (occ < depth) begin
                    acc[(t - 1) / 2] = 1'b1;
                    occ++;
                end
            end
            if (pop_now) begin
                occ--;
                free_at = t + 3;
            end
        end
        return acc;
    endfunction

    initial begin
        logic [31:0] acc;
        logic [7:0]  wd [14];
        int          nacc;
        bit          seen;
        int          r;

        drive(OP_NONE, 8'h00);
        bus.core_rdata = '0;
        m_addr = 4'h0;
        m_ok   = 1'b1;
        m_chip = 2'd0;

        repeat (3) @(negedge clk);
        check("rst_dout", bus.dout, 8'hFF);
        check("rst_addr", bus.core_addr, 4'h0);
        check("rst_din", bus.core_din, 8'h00);
        check("rst_cs_n", bus.core_cs_n, 2'b11);
        check("rst_wr_n", bus.core_wr_n, 1'b1);
        check("rst_chip", bus.chip_sel, 2'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        rst = 1'b0;
        idle(2);

        // Write latency: strobe visible in the cycle after the 3rd edge following E0.
        latch_op(8'h07);
        idle(3);
        obs_q.delete();
        drive(OP_WRITE, 8'h3C);
        @(negedge clk);
        check("t1_e0_wr_n", bus.core_wr_n, 1'b1);
        drive(OP_NONE, 8'h00);
        @(negedge clk);
        check("t1_e1_wr_n", bus.core_wr_n, 1'b1);
        @(negedge clk);
        check("t1_e2_wr_n", bus.core_wr_n, 1'b1);
        @(negedge clk);
        check("t1_e3_cs_n", bus.core_cs_n, 2'b10);
        check("t1_e3_wr_n", bus.core_wr_n, 1'b0);
        check("t1_e3_addr", bus.core_addr, 4'h7);
        check("t1_e3_din", bus.core_din, 8'h3C);
        @(negedge clk);
        check("t1_e4_wr_n", bus.core_wr_n, 1'b1);
        check("t1_e4_cs_n", bus.core_cs_n, 2'b11);
        check("t1_e4_addr", bus.core_addr, 4'h7);
        idle(3);
        obs_q.delete();

        latch_op(8'hFE);
        latch_op(8'h08);
        write_op(8'h0F);
        drain_compare("t2");
        check("t2_chip", bus.chip_sel, 2'd1);
        latch_op(8'hFD);
        idle(2);
        check("t2_chip_hold", bus.chip_sel, m_chip);

        latch_op(8'h25);
        write_op(8'h11);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) seen = 1'b1;
        end
        check("t4_busy", seen, 1'b0);
        drain_compare("t4");

        latch_op(8'hFF);
        latch_op(8'h03);
        bus.core_rdata = 16'h5AA5;
        idle(2);
        drive(OP_READ, 8'h00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_dout", bus.dout, (k >= 2) ? 8'hA5 : 8'hFF);
            if (k == 3) begin
                check("t5_cs_n", bus.core_cs_n, 2'b10);
                check("t5_addr", bus.core_addr, 4'h3);
            end
        end
        drive(OP_NONE, 8'h00);
        @(negedge clk);
        check("t5_tail", bus.dout, 8'hA5);
        @(negedge clk);
        check("t5_end", bus.dout, 8'hFF);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      latch_op({4'h0, 4'($urandom)});
            else if (r < 50) latch_op({6'h3F, 2'($urandom)});
            else if (r < 60) latch_op(8'($urandom_range(64, 251)));
            else if (r < 85) write_op(8'($urandom));
            else             read_op();
            idle(4);
        end
        drain_compare("rnd");
        check("rnd_ovf", bus.ovf, 1'b0);

        latch_op(8'h0A);
        idle(2);
        wait_idle();
        obs_q.delete();
        exp_q.delete();
        acc  = ovf_model(14, FDEPTH);
        nacc = 0;
        for (int i = 0; i < 14; i++) begin
            wd[i] = 8'($urandom);
            if (acc[i]) nacc++;
        end
        for (int i = 0; i < 14; i++) begin
            bus_op(OP_WRITE, wd[i]);
            if (acc[i]) exp_q.push_back(mk(m_chip, m_addr, wd[i]));
        end
        idle(1);
        check("t3_ovf", bus.ovf, (nacc < 14) ? 1'b1 : 1'b0);
        drain_compare("t3");

        latch_op(8'h05);
        write_op(8'hC3);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.core_wr_n === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_strobe_seen", seen, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_cs_n", bus.core_cs_n, 2'b11);
        check("t6_async_wr_n", bus.core_wr_n, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        m_addr = 4'h0;
        m_ok   = 1'b1;
        m_chip = 2'd0;
        @(negedge clk);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_ovf", bus.ovf, 1'b0);
        check("t6_chip", bus.chip_sel, 2'd0);
        write_op(8'h99);
        drain_compare("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
